// File: rtl/memseq_pkg.sv
// memseq_pkg: shared types and constants for the memory sequencer.
//   state_e    : sequencer FSM states
//   RD_LAT     : cycles from Mem_Addr presented to Rd_Valid/Rd_Data
//   clog2_min1 : counter width helper (never returns 0)
package memseq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int unsigned RD_LAT = 2;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memseq_rd_pipe.sv
// memseq_rd_pipe: tracks issued read addresses through the BRAM latency and
// captures DOut into the read stream register.
//   Clk, Reset_N : clock, asynchronous active-low reset
//   issue        : an address is being registered onto Mem_Addr this cycle
//   issue_last   : that address is the final one of the burst
//   mem_dout     : memory DOut
//   rd_data      : captured read word
//   rd_valid     : rd_data valid this cycle
//   rd_last      : rd_data is the final word of the burst
module memseq_rd_pipe
  import memseq_pkg::*;
#(
  parameter int unsigned DataWidth = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 issue,
  input  logic                 issue_last,
  input  logic [DataWidth-1:0] mem_dout,
  output logic [DataWidth-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_last
);

  // Stage 0 lines up with Mem_Addr, the final stage lines up with DOut.
  logic [RD_LAT-1:0] vld_sh;
  logic [RD_LAT-1:0] lst_sh;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      vld_sh   <= '0;
      lst_sh   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
    end else begin
      vld_sh[0] <= issue;
      lst_sh[0] <= issue && issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sh[i] <= vld_sh[i-1];
        lst_sh[i] <= lst_sh[i-1];
      end
      rd_valid <= vld_sh[RD_LAT-1];
      rd_last  <= vld_sh[RD_LAT-1] && lst_sh[RD_LAT-1];
      if (vld_sh[RD_LAT-1]) begin
        rd_data <= mem_dout;
      end
    end
  end

endmodule

// File: rtl/memory_sequencer.sv
// memory_sequencer: burst initiator for a single-port synchronous BRAM.
// Accepts one write or read burst at a time and is the sole driver of the
// memory port.
//   Clk, Reset_N          : clock, asynchronous active-low reset
//   Req_*                 : burst request (Len is word count minus 1)
//   Wr_Data/Valid/Ready   : write stream in
//   Rd_Data/Valid         : read stream out, no backpressure
//   Done                  : one-cycle burst-complete pulse
//   Mem_Addr/DIn/WE/DOut  : memory port
// Optional build macro MEMSEQ_WRAP_GUARD_EN: adds output Err; a request whose
// address range would wrap past the top of memory is rejected with Err+Done.
module memory_sequencer
  import memseq_pkg::*;
#(
  parameter int unsigned AddrWidth = 8,
  parameter int unsigned DataWidth = 16
) (
  input  logic                 Clk,
  input  logic                 Reset_N,
  input  logic                 Req_Valid,
  output logic                 Req_Ready,
  input  logic                 Req_Write,
  input  logic [AddrWidth-1:0] Req_Addr,
  input  logic [AddrWidth-1:0] Req_Len,
  input  logic [DataWidth-1:0] Wr_Data,
  input  logic                 Wr_Valid,
  output logic                 Wr_Ready,
  output logic [DataWidth-1:0] Rd_Data,
  output logic                 Rd_Valid,
  output logic                 Done,
`ifdef MEMSEQ_WRAP_GUARD_EN
  output logic                 Err,
`endif
  output logic [AddrWidth-1:0] Mem_Addr,
  output logic [DataWidth-1:0] Mem_DIn,
  output logic                 Mem_WE,
  input  logic [DataWidth-1:0] Mem_DOut
);

  state_e               state;
  state_e               state_nxt;
  logic [AddrWidth-1:0] addr_q;
  logic [AddrWidth-1:0] addr_d;
  logic [AddrWidth-1:0] rem_q;
  logic [AddrWidth-1:0] rem_d;
  logic [AddrWidth-1:0] mem_addr_d;
  logic [DataWidth-1:0] mem_din_d;
  logic                 mem_we_d;
  logic                 done_d;
  logic                 issue;
  logic                 issue_last;
  logic                 rd_last;
  logic                 wrap_c;
`ifdef MEMSEQ_WRAP_GUARD_EN
  logic                 err_d;
  logic [AddrWidth:0]   span_c;

  // Carry out of start+len means the burst would run past the last word.
  assign span_c = {1'b0, Req_Addr} + {1'b0, Req_Len};
  assign wrap_c = span_c[AddrWidth];
`else
  assign wrap_c = 1'b0;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state    <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      Mem_Addr <= '0;
      Mem_DIn  <= '0;
      Mem_WE   <= 1'b0;
      Done     <= 1'b0;
`ifdef MEMSEQ_WRAP_GUARD_EN
      Err      <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      Mem_Addr <= mem_addr_d;
      Mem_DIn  <= mem_din_d;
      Mem_WE   <= mem_we_d;
      Done     <= done_d;
`ifdef MEMSEQ_WRAP_GUARD_EN
      Err      <= err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Req_Valid) begin
          if (wrap_c) begin
            state_nxt = DONE;
          end else begin
            state_nxt = Req_Write ? WRITE : READ;
          end
        end
      end
      WRITE: begin
        if (Wr_Valid && (rem_q == '0)) begin
          state_nxt = DONE;
        end
      end
      READ: begin
        if (rem_q == '0) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (rd_last) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshakes, counter updates and next values of registered outputs.
  always_comb begin
    Req_Ready  = 1'b0;
    Wr_Ready   = 1'b0;
    addr_d     = addr_q;
    rem_d      = rem_q;
    mem_addr_d = Mem_Addr;
    mem_din_d  = Mem_DIn;
    mem_we_d   = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    done_d     = (state_nxt == DONE);
`ifdef MEMSEQ_WRAP_GUARD_EN
    err_d      = 1'b0;
`endif
    case (state)
      IDLE: begin
        Req_Ready = 1'b1;
        if (Req_Valid) begin
          addr_d = Req_Addr;
          rem_d  = Req_Len;
`ifdef MEMSEQ_WRAP_GUARD_EN
          err_d  = wrap_c;
`endif
        end
      end
      WRITE: begin
        Wr_Ready = 1'b1;
        if (Wr_Valid) begin
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q;
          mem_din_d  = Wr_Data;
          addr_d     = addr_q + AddrWidth'(1);
          if (rem_q != '0) begin
            rem_d = rem_q - AddrWidth'(1);
          end
        end
      end
      READ: begin
        mem_addr_d = addr_q;
        addr_d     = addr_q + AddrWidth'(1);
        issue      = 1'b1;
        if (rem_q == '0) begin
          issue_last = 1'b1;
        end else begin
          rem_d = rem_q - AddrWidth'(1);
        end
      end
      default: ;
    endcase
  end

  memseq_rd_pipe #(
    .DataWidth(DataWidth)
  ) u_rd_pipe (
    .Clk       (Clk),
    .Reset_N   (Reset_N),
    .issue     (issue),
    .issue_last(issue_last),
    .mem_dout  (Mem_DOut),
    .rd_data   (Rd_Data),
    .rd_valid  (Rd_Valid),
    .rd_last   (rd_last)
  );

endmodule
